// File: rtl/dp_operand_loader.sv
// Collects PIXEL_N pixel/weight beats onto packed buses, launches the
// dot-product engine and captures its result after a fixed drain time.
module dp_operand_loader #(
    parameter int PIXEL_N      = 10,
    parameter int PIXEL_SIZE   = 10,
    parameter int WEIGHT_SIZE  = 19,
    parameter int VAL_SIZE     = 26,
    parameter int DRAIN_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           GlobalReset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [PIXEL_SIZE-1:0]          in_pixel,
    input  logic [WEIGHT_SIZE-1:0]         in_weight,
    output logic [PIXEL_N*PIXEL_SIZE-1:0]  Pixels,
    output logic [PIXEL_N*WEIGHT_SIZE-1:0] Weights,
    output logic                           dp_start,
    output logic                           vec_valid,
    input  logic [VAL_SIZE-1:0]            value,
    output logic                           result_valid,
    input  logic                           result_ready,
    output logic [VAL_SIZE-1:0]            result_data
);
    localparam int IW = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
    localparam int CW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(PIXEL_N - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {FILL, HOLD, OUT} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state        <= FILL;
            idx          <= '0;
            cnt          <= '0;
            Pixels       <= '0;
            Weights      <= '0;
            result_data  <= '0;
            dp_start     <= 1'b0;
            vec_valid    <= 1'b0;
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
        end else if (flush) begin
            state        <= FILL;
            idx          <= '0;
            cnt          <= '0;
            Pixels       <= '0;
            Weights      <= '0;
            result_data  <= '0;
            dp_start     <= 1'b0;
            vec_valid    <= 1'b0;
            result_valid <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            dp_start <= 1'b0;
            unique case (state)
                FILL: begin
                    if (in_valid) begin
                        Pixels[idx*PIXEL_SIZE +: PIXEL_SIZE]    <= in_pixel;
                        Weights[idx*WEIGHT_SIZE +: WEIGHT_SIZE] <= in_weight;
                        if (idx == LAST_IDX) begin
                            idx       <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            vec_valid <= 1'b1;
                            dp_start  <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // value is only trusted on the final drain edge
                    if (cnt == LAST_CNT) begin
                        cnt          <= '0;
                        result_data  <= value;
                        state        <= OUT;
                        vec_valid    <= 1'b0;
                        result_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        state        <= FILL;
                        result_valid <= 1'b0;
                        in_ready     <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_dp_operand_loader.sv
// Scoreboard bench for dp_operand_loader: a transaction-level model tracks
// the buses, phase and queued results; a monitor compares every cycle.
module tb_dp_operand_loader;
    localparam int N  = 10;
    localparam int PS = 10;
    localparam int WS = 19;
    localparam int VS = 26;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          GlobalReset = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          result_ready = 1'b0;
    logic          in_ready, dp_start, vec_valid, result_valid;
    logic [PS-1:0] in_pixel = '0;
    logic [WS-1:0] in_weight = '0;
    logic [VS-1:0] value = '0;
    logic [VS-1:0] result_data;
    logic [N*PS-1:0] Pixels;
    logic [N*WS-1:0] Weights;

    int checks = 0;
    int errors = 0;

    typedef enum {M_FILL, M_HOLD, M_OUT} phase_t;
    phase_t        mst = M_FILL;
    logic          first_hold = 1'b0;
    int            k = 0;
    logic [PS-1:0] mp[N];
    logic [WS-1:0] mw[N];
    logic [VS-1:0] m_res = '0;
    logic [VS-1:0]   res_q[$];
    logic [N*PS-1:0] vp_q[$];
    logic [N*WS-1:0] vw_q[$];

    dp_operand_loader #(
        .PIXEL_N(N), .PIXEL_SIZE(PS), .WEIGHT_SIZE(WS),
        .VAL_SIZE(VS), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk), .GlobalReset(GlobalReset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_weight(in_weight),
        .Pixels(Pixels), .Weights(Weights),
        .dp_start(dp_start), .vec_valid(vec_valid),
        .value(value), .result_valid(result_valid),
        .result_ready(result_ready), .result_data(result_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N*PS-1:0] pack_p();
        logic [N*PS-1:0] r;
        for (int j = 0; j < N; j++) r[j*PS +: PS] = mp[j];
        return r;
    endfunction

    function automatic logic [N*WS-1:0] pack_w();
        logic [N*WS-1:0] r;
        for (int j = 0; j < N; j++) r[j*WS +: WS] = mw[j];
        return r;
    endfunction

    task automatic clear_model(input logic drop_res);
        for (int j = 0; j < N; j++) begin
            mp[j] = '0;
            mw[j] = '0;
        end
        k = 0;
        mst = M_FILL;
        first_hold = 1'b0;
        m_res = '0;
        if (drop_res) res_q.delete();
    endtask

    // Monitor: phase flags, buses and result register against the model
    int   cyc = 0;
    int   start_cyc = -1;
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        cyc++;
        chk("in_ready", in_ready, mst == M_FILL);
        chk("vec_valid", vec_valid, mst == M_HOLD);
        chk("result_valid", result_valid, mst == M_OUT);
        chk("dp_start", dp_start, first_hold);
        chk("pixels", Pixels, pack_p());
        chk("weights", Weights, pack_w());
        chk("result_data", result_data, m_res);
        if (dp_start) begin
            start_cyc = cyc;
            if (vp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vec_q: dp_start with no vector expected");
            end else begin
                chk("vec_pixels", Pixels, vp_q.pop_front());
                chk("vec_weights", Weights, vw_q.pop_front());
            end
        end
        if (result_valid && !prev_rv)
            chk("latency", 256'(cyc - start_cyc), 256'(D));
        if (result_valid && result_ready) begin
            if (res_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL res_q: result accepted with none expected");
            end else begin
                chk("result", result_data, res_q.pop_front());
            end
        end
        prev_rv = result_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
        first_hold = 1'b0;
    endtask

    task automatic beat(input logic [PS-1:0] p, input logic [WS-1:0] w,
                        input logic fl);
        in_valid = 1'b1;
        in_pixel = p;
        in_weight = w;
        flush = fl;
        result_ready = 1'($urandom);
        step();
        in_valid = 1'b0;
        flush = 1'b0;
        result_ready = 1'b0;
        if (fl) begin
            clear_model(1'b0);
        end else begin
            mp[k] = p;
            mw[k] = w;
            if (k == N - 1) begin
                k = 0;
                mst = M_HOLD;
                first_hold = 1'b1;
                vp_q.push_back(pack_p());
                vw_q.push_back(pack_w());
            end else begin
                k++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_pixel = PS'($urandom);
            result_ready = 1'($urandom);
            step();
        end
        result_ready = 1'b0;
    endtask

    task automatic load(input int gap_max);
        for (int j = 0; j < N; j++) begin
            beat(PS'($urandom), WS'($urandom), 1'b0);
            if (j < N - 1) idle($urandom_range(gap_max, 0));
        end
    endtask

    // HOLD phase: value is noise except before the edge that captures it
    task automatic drain(input logic [VS-1:0] v, input int abort_at,
                         input logic junk);
        for (int i = 1; i <= D; i++) begin
            in_valid = junk;
            in_pixel = PS'($urandom);
            in_weight = WS'($urandom);
            if (i == D) begin
                value = v;
                res_q.push_back(v);
            end else begin
                value = VS'($urandom);
            end
            if (i == abort_at) begin
                #2;
                GlobalReset = 1'b0;
                clear_model(1'b1);
                #1;
                chk("rst_in_ready", in_ready, 1'b1);
                chk("rst_vec_valid", vec_valid, 1'b0);
                chk("rst_dp_start", dp_start, 1'b0);
                chk("rst_result_valid", result_valid, 1'b0);
                chk("rst_pixels", Pixels, '0);
                chk("rst_weights", Weights, '0);
                in_valid = 1'b0;
                step();
                GlobalReset = 1'b1;
                return;
            end
            step();
        end
        in_valid = 1'b0;
        mst = M_OUT;
        m_res = v;
    endtask

    task automatic take(input int bp, input logic junk);
        for (int i = 0; i < bp; i++) begin
            result_ready = 1'b0;
            value = VS'($urandom);
            in_valid = junk;
            in_pixel = PS'($urandom);
            step();
        end
        result_ready = 1'b1;
        in_valid = junk;
        step();
        result_ready = 1'b0;
        in_valid = 1'b0;
        mst = M_FILL;
        chk("in_ready_after_accept", in_ready, 1'b1);
    endtask

    logic [PS-1:0] p0;

    initial begin
        clear_model(1'b1);
        #1 GlobalReset = 1'b0;
        #1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_vec_valid", vec_valid, 1'b0);
        chk("reset_result_valid", result_valid, 1'b0);
        chk("reset_dp_start", dp_start, 1'b0);
        chk("reset_pixels", Pixels, '0);
        chk("reset_result_data", result_data, '0);
        step();
        step();
        GlobalReset = 1'b1;

        // Basic load, accepted from the first edge after reset release
        for (int j = 0; j < N; j++)
            beat(PS'(j + 1), WS'(100 + j), 1'b0);
        chk("dp_start_after_beat9", dp_start, 1'b1);
        chk("pixel_lane0", Pixels[0 +: PS], 256'd1);
        chk("pixel_lane9", Pixels[9*PS +: PS], 256'd10);
        chk("weight_lane9", Weights[9*WS +: WS], 256'd109);
        drain(26'h0ABCDE, 0, 1'b1);
        take(0, 1'b0);
        chk("result_0abcde", result_data, 256'h0ABCDE);

        // Backpressure with a changing value and an offered beat
        load(0);
        drain(26'h0ABCDE, 0, 1'b0);
        take(5, 1'b1);
        chk("bp_result", result_data, 256'h0ABCDE);

        // Gapped input
        for (int j = 0; j < N; j++) begin
            beat(PS'($urandom), WS'($urandom), 1'b0);
            if (j < N - 1) idle(1);
        end
        drain(VS'($urandom), 0, 1'b1);
        take(1, 1'b0);

        // Flush racing the sixth beat
        for (int j = 0; j < 5; j++)
            beat(PS'($urandom), WS'($urandom), 1'b0);
        beat(PS'($urandom), WS'($urandom), 1'b1);
        chk("flush_pixels", Pixels, '0);
        chk("flush_result", result_data, '0);
        p0 = PS'($urandom);
        beat(p0, WS'($urandom), 1'b0);
        chk("after_flush_lane0", Pixels[0 +: PS], 256'(p0));
        for (int j = 1; j < N; j++)
            beat(PS'($urandom), WS'($urandom), 1'b0);
        drain(VS'($urandom), 0, 1'b0);
        take(2, 1'b1);

        // Async reset in the middle of HOLD
        load(1);
        drain(VS'($urandom), 6, 1'b0);
        idle(3);
        load(0);
        drain(VS'($urandom), 0, 1'b0);
        take(0, 1'b0);

        // Randomized traffic with occasional flushes while filling
        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(3, 0) == 0) begin
                for (int j = 0; j < $urandom_range(N - 1, 1); j++)
                    beat(PS'($urandom), WS'($urandom), 1'b0);
                beat(PS'($urandom), WS'($urandom), 1'b1);
            end
            load(2);
            drain(VS'($urandom), 0, 1'($urandom));
            take($urandom_range(4, 0), 1'($urandom));
            idle($urandom_range(2, 0));
        end

        idle(2);
        chk("res_q_empty", 256'(res_q.size()), '0);
        chk("vec_q_empty", 256'(vp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
